// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: screen window constants and the frame-buffer arbiter state type.
package cpu_pkg;

  localparam int SCREEN_BASE  = 16384;
  localparam int SCREEN_WORDS = 8192;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_FLUSH = 2'd3
  } t_arb_state;

endpackage

// File: rtl/scr_wr_fifo.sv
// Screen write queue: synchronous FIFO of (address, data) pairs plus a parallel lookup
// telling whether any queued entry targets a given address.
module scr_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 13,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic [AW-1:0]            match_addr,
  output logic                     match
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra phase bit so full and empty are distinguishable.
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  assign level     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_addr = addr_q[rd_ptr[PW-1:0]];
  assign head_data = data_q[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr[PW-1:0]] <= push_addr;
      data_q[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(PW'(i) - rd_ptr[PW-1:0])} < level) && (addr_q[i] == match_addr))
        match = 1'b1;
    end
  end

endmodule

// File: rtl/screen_mem_arbiter.sv
// Shares the single-port screen frame buffer between queued CPU stores and VGA pixel reads;
// reads win unless the queue is full, starved, or holds a pending write to the read address.
module screen_mem_arbiter #(
  parameter int DATA_W      = 16,
  parameter int SCREEN_BASE = cpu_pkg::SCREEN_BASE,
  parameter int SCREEN_AW   = $clog2(cpu_pkg::SCREEN_WORDS),
  parameter int FIFO_DEPTH  = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 cpu_write_m,
  input  logic [14:0]          cpu_data_addr,
  input  logic [DATA_W-1:0]    cpu_out_m,
  input  logic                 vga_rd_req,
  input  logic [SCREEN_AW-1:0] vga_rd_addr,
  output logic                 vga_rd_gnt,
  output logic [DATA_W-1:0]    vga_rd_data,
  output logic                 vga_rd_valid,
  output logic [SCREEN_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_wren,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [2:0]           fifo_level
);

  import cpu_pkg::*;

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 in_window;
  logic                 push;
  logic                 pop;
  logic [SCREEN_AW-1:0] push_addr;
  logic [SCREEN_AW-1:0] head_addr;
  logic [DATA_W-1:0]    head_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_match;
  logic [LW-1:0]        fifo_lvl;
  logic [CW-1:0]        starve_cnt;
  t_arb_state           slot;
  t_arb_state           state;

  assign in_window = ({17'd0, cpu_data_addr} >= 32'(SCREEN_BASE)) &&
                     ({17'd0, cpu_data_addr} <  32'(SCREEN_BASE + 2**SCREEN_AW));
  assign push      = cpu_write_m && in_window;
  assign push_addr = SCREEN_AW'(cpu_data_addr - 15'(SCREEN_BASE));

  scr_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (SCREEN_AW),
    .DW    (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .resetN     (resetN),
    .push       (push),
    .push_addr  (push_addr),
    .push_data  (cpu_out_m),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_lvl),
    .match_addr (vga_rd_addr),
    .match      (fifo_match)
  );

  // Slot decision for this cycle; a queued write to the read address must land before the read.
  always_comb begin
    slot = ARB_IDLE;
    if (!fifo_empty && (fifo_full || starve_cnt == CW'(STARVE_MAX)))
      slot = ARB_WRITE;
    else if (vga_rd_req && fifo_match)
      slot = ARB_FLUSH;
    else if (vga_rd_req)
      slot = ARB_READ;
    else if (!fifo_empty)
      slot = ARB_WRITE;
  end

  assign pop         = (slot == ARB_WRITE) || (slot == ARB_FLUSH);
  assign vga_rd_gnt  = resetN && (slot == ARB_READ);
  assign vga_rd_data = vga_rd_valid ? mem_rdata : '0;
  assign fifo_level  = 3'(fifo_lvl);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ARB_IDLE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wren     <= 1'b0;
      vga_rd_valid <= 1'b0;
      starve_cnt   <= '0;
    end else begin
      state        <= slot;
      // The read address went out last cycle, so the frame buffer answers now.
      vga_rd_valid <= (state == ARB_READ);
      case (slot)
        ARB_WRITE, ARB_FLUSH: begin
          mem_addr  <= head_addr;
          mem_wdata <= head_data;
          mem_wren  <= 1'b1;
        end
        ARB_READ: begin
          mem_addr  <= vga_rd_addr;
          mem_wren  <= 1'b0;
        end
        default: mem_wren <= 1'b0;
      endcase
      if (fifo_empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Bench for screen_mem_arbiter: a frame-buffer model, a write/read scoreboard and one task per scenario.
module tb_screen_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          resetN;
  logic          cpu_write_m;
  logic [14:0]   cpu_data_addr;
  logic [DW-1:0] cpu_out_m;
  logic          vga_rd_req;
  logic [AW-1:0] vga_rd_addr;
  logic          vga_rd_gnt;
  logic [DW-1:0] vga_rd_data;
  logic          vga_rd_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    fifo_level;

  int tests_run = 0;
  int failed    = 0;

  logic [AW+DW-1:0] wr_exp_q[$];
  logic [DW-1:0]    rd_exp_q[$];
  logic [DW-1:0]    mem_model[int];
  logic [DW-1:0]    shadow[int];
  logic [AW+DW-1:0] exp_w;
  logic [DW-1:0]    exp_r;
  logic [DW-1:0]    rd_tmp;

  screen_mem_arbiter dut (
    .clk           (clk),
    .resetN        (resetN),
    .cpu_write_m   (cpu_write_m),
    .cpu_data_addr (cpu_data_addr),
    .cpu_out_m     (cpu_out_m),
    .vga_rd_req    (vga_rd_req),
    .vga_rd_addr   (vga_rd_addr),
    .vga_rd_gnt    (vga_rd_gnt),
    .vga_rd_data   (vga_rd_data),
    .vga_rd_valid  (vga_rd_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wren      (mem_wren),
    .mem_rdata     (mem_rdata),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a) ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] shadow_val(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // Frame buffer: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    rd_tmp = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : init_val(int'(mem_addr));
    if (mem_wren) mem_model[int'(mem_addr)] = mem_wdata;
    mem_rdata <= rd_tmp;
  end

  // Scoreboard: writes leave the DUT in store order, reads return the newest CPU value.
  always @(negedge clk) begin
    if (!resetN) begin
      wr_exp_q.delete();
      rd_exp_q.delete();
    end else begin
      if (mem_wren) begin
        tests_run++;
        if (wr_exp_q.size() == 0) begin
          failed++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
        end else begin
          exp_w = wr_exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp_w) begin
            failed++;
            $display("FAIL wr_order: got addr %0h data %0h, required addr %0h data %0h",
                     mem_addr, mem_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
          end
        end
      end
      if (vga_rd_valid) begin
        tests_run++;
        if (rd_exp_q.size() == 0) begin
          failed++;
          $display("FAIL rd_unexpected: got valid data %0h, required no valid", vga_rd_data);
        end else begin
          exp_r = rd_exp_q.pop_front();
          if (vga_rd_data !== exp_r) begin
            failed++;
            $display("FAIL rd_data: got %0h, required %0h", vga_rd_data, exp_r);
          end
        end
      end
      if (vga_rd_gnt) rd_exp_q.push_back(shadow_val(int'(vga_rd_addr)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_write_m   = 1'b0;
    cpu_data_addr = '0;
    cpu_out_m     = '0;
    vga_rd_req    = 1'b0;
    vga_rd_addr   = '0;
  endtask

  task automatic drive_store(input logic [14:0] a, input logic [DW-1:0] d);
    cpu_write_m   = 1'b1;
    cpu_data_addr = a;
    cpu_out_m     = d;
    if (a >= 15'h4000 && a < 15'h6000) begin
      wr_exp_q.push_back({AW'(a - 15'h4000), d});
      shadow[int'(AW'(a - 15'h4000))] = d;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpu_write_m   = 1'($urandom_range(0, 1));
      cpu_data_addr = 15'($urandom_range(0, 32767));
      cpu_out_m     = 16'($urandom);
      vga_rd_req    = 1'($urandom_range(0, 1));
      vga_rd_addr   = 13'($urandom_range(0, 8191));
      @(negedge clk);
      tests_run++;
      if ({vga_rd_gnt, vga_rd_valid, vga_rd_data, mem_addr, mem_wdata, mem_wren, fifo_level} !== '0) begin
        failed++;
        $display("FAIL reset_outputs: gnt %0b valid %0b rdata %0h addr %0h wdata %0h wren %0b level %0d, required all 0",
                 vga_rd_gnt, vga_rd_valid, vga_rd_data, mem_addr, mem_wdata, mem_wren, fifo_level);
      end
    end
    idle_inputs();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    drive_store(15'h4005, 16'hABCD);
    tick();
    idle_inputs();
    tests_run++;
    if (fifo_level !== 3'd1) begin
      failed++;
      $display("FAIL store_level: got %0d, required 1", fifo_level);
    end
    tests_run++;
    if (mem_wren !== 1'b0) begin
      failed++;
      $display("FAIL store_early_wren: got %0b, required 0", mem_wren);
    end
    tick();
    tests_run++;
    if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, 13'd5, 16'hABCD}) begin
      failed++;
      $display("FAIL store_write: got wren %0b addr %0h data %0h, required 1 5 abcd", mem_wren, mem_addr, mem_wdata);
    end
    tests_run++;
    if (fifo_level !== 3'd0) begin
      failed++;
      $display("FAIL store_drained: got %0d, required 0", fifo_level);
    end
    tick();
  endtask

  task automatic test_window();
    drive_store(15'h3FFF, 16'h1111);
    tick();
    drive_store(15'h6000, 16'h2222);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem_wren !== 1'b0 || fifo_level !== 3'd0) begin
        failed++;
        $display("FAIL window_ignore: got wren %0b level %0d, required 0 0", mem_wren, fifo_level);
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    logic exp_gnt;
    vga_rd_req  = 1'b1;
    vga_rd_addr = 13'd100;
    for (int k = 0; k < 28; k++) begin
      if (k < 3) drive_store(15'h4010 + 15'(k), 16'($urandom));
      else cpu_write_m = 1'b0;
      exp_gnt = !(k == 9 || k == 18 || k == 27);
      @(negedge clk);
      tests_run++;
      if (vga_rd_gnt !== exp_gnt) begin
        failed++;
        $display("FAIL starve_gnt cycle %0d: got %0b, required %0b", k, vga_rd_gnt, exp_gnt);
      end
      tick();
    end
    tests_run++;
    if (fifo_level !== 3'd0) begin
      failed++;
      $display("FAIL starve_drain: got level %0d, required 0", fifo_level);
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_coherence();
    bit seen;
    drive_store(15'h4064, 16'h1234);
    tick();
    cpu_write_m = 1'b0;
    vga_rd_req  = 1'b1;
    vga_rd_addr = 13'd100;
    @(negedge clk);
    tests_run++;
    if (vga_rd_gnt !== 1'b0) begin
      failed++;
      $display("FAIL coh_hold: got gnt %0b, required 0", vga_rd_gnt);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (vga_rd_gnt !== 1'b1 || {mem_wren, mem_addr, mem_wdata} !== {1'b1, 13'd100, 16'h1234}) begin
      failed++;
      $display("FAIL coh_flush: got gnt %0b wren %0b addr %0h data %0h, required 1 1 64 1234",
               vga_rd_gnt, mem_wren, mem_addr, mem_wdata);
    end
    tick();
    vga_rd_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (vga_rd_valid) begin
        seen = 1'b1;
        tests_run++;
        if (vga_rd_data !== 16'h1234 || i != 1) begin
          failed++;
          $display("FAIL coh_data: got %0h after %0d, required 1234 after 1", vga_rd_data, i);
        end
      end
    end
    if (!seen) begin
      tests_run++;
      failed++;
      $display("FAIL coh_timeout: got no vga_rd_valid, required one");
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_lvl;
    logic       exp_gnt;
    bit         done;
    bit         got_gnt;
    vga_rd_req  = 1'b1;
    vga_rd_addr = 13'd4000;
    for (int k = 0; k < 20; k++) begin
      drive_store(15'h4000 + 15'(200 + k), 16'($urandom));
      exp_lvl = (k < 4) ? 3'(k) : 3'd4;
      exp_gnt = (k < 4);
      @(negedge clk);
      tests_run++;
      if (fifo_level !== exp_lvl || vga_rd_gnt !== exp_gnt) begin
        failed++;
        $display("FAIL full_burst cycle %0d: got level %0d gnt %0b, required %0d %0b",
                 k, fifo_level, vga_rd_gnt, exp_lvl, exp_gnt);
      end
      tick();
    end
    cpu_write_m = 1'b0;
    done = 1'b0;
    got_gnt = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (vga_rd_gnt) got_gnt = 1'b1;
      if (wr_exp_q.size() == 0 && fifo_level == 3'd0) done = 1'b1;
      tick();
    end
    tests_run++;
    if (!done || !got_gnt) begin
      failed++;
      $display("FAIL burst_drain: got done %0b gnt_seen %0b left %0d, required 1 1 0", done, got_gnt, wr_exp_q.size());
    end
    idle_inputs();
    repeat (3) tick();

    // Reset while a granted read is in flight and a store is queued.
    vga_rd_req  = 1'b1;
    vga_rd_addr = 13'd4001;
    drive_store(15'h4000 + 15'd300, 16'hBEEF);
    @(negedge clk);
    tests_run++;
    if (vga_rd_gnt !== 1'b1) begin
      failed++;
      $display("FAIL abort_gnt: got %0b, required 1", vga_rd_gnt);
    end
    tick();
    idle_inputs();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    shadow = mem_model;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (vga_rd_valid !== 1'b0 || mem_wren !== 1'b0 || fifo_level !== 3'd0) begin
        failed++;
        $display("FAIL abort_quiet: got valid %0b wren %0b level %0d, required 0 0 0", vga_rd_valid, mem_wren, fifo_level);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_store();
    test_window();
    test_starvation();
    test_coherence();
    test_back_to_back();
    repeat (4) tick();
    tests_run++;
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failed++;
      $display("FAIL final_queues: got %0d writes %0d reads pending, required 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
